// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives one row low at a time, synchronises the
// columns, debounces press and release, and emits one key code per press.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV        = 12000,
  parameter int unsigned DEBOUNCE_CYCLES = 240000
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic [3:0] col_i,
  output logic [3:0] row_o,
  output logic [3:0] key_o,
  output logic       key_valid_o,
  output logic       key_held_o
);

  localparam int unsigned SlotW = $clog2(SCAN_DIV);
  localparam int unsigned DcntW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [SlotW-1:0] SlotLast = SlotW'(SCAN_DIV - 1);
  localparam logic [DcntW-1:0] DcntLast = DcntW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {StScan, StDebounce, StHeld, StRelease} state_e;

  state_e           state_q;
  logic [3:0]       col_meta_q;
  logic [3:0]       colsync_q;
  logic [1:0]       r_q;
  logic [1:0]       lc_q;
  logic [SlotW-1:0] slot_q;
  logic [DcntW-1:0] dcnt_q;
  logic [3:0]       key_q;
  logic             key_valid_q;
  logic             key_held_q;

  logic [1:0]       low_col;
  logic             lc_high;

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    code = 4'h0;
    case ({r, c})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = 4'hA;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = 4'hB;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hC;
      4'b11_00: code = 4'hE;
      4'b11_01: code = 4'h0;
      4'b11_10: code = 4'hF;
      4'b11_11: code = 4'hD;
      default:  code = 4'h0;
    endcase
    return code;
  endfunction

  // Lowest-index low column wins when several are pressed on one row.
  always_comb begin
    low_col = 2'd3;
    if (!colsync_q[0])      low_col = 2'd0;
    else if (!colsync_q[1]) low_col = 2'd1;
    else if (!colsync_q[2]) low_col = 2'd2;
  end

  assign lc_high = colsync_q[lc_q];

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q     <= StScan;
      col_meta_q  <= 4'b1111;
      colsync_q   <= 4'b1111;
      r_q         <= 2'd0;
      lc_q        <= 2'd0;
      slot_q      <= '0;
      dcnt_q      <= '0;
      key_q       <= 4'h0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      col_meta_q  <= col_i;
      colsync_q   <= col_meta_q;
      key_valid_q <= 1'b0;
      unique case (state_q)
        StScan: begin
          if (slot_q == SlotLast) begin
            slot_q <= '0;
            if (colsync_q != 4'b1111) begin
              lc_q    <= low_col;
              dcnt_q  <= '0;
              state_q <= StDebounce;
            end else begin
              r_q <= r_q + 2'd1;
            end
          end else begin
            slot_q <= slot_q + SlotW'(1);
          end
        end
        StDebounce: begin
          if (lc_high) begin
            state_q <= StScan;
            r_q     <= r_q + 2'd1;
            slot_q  <= '0;
          end else if (dcnt_q == DcntLast) begin
            key_q       <= key_map(r_q, lc_q);
            key_valid_q <= 1'b1;
            key_held_q  <= 1'b1;
            state_q     <= StHeld;
          end else begin
            dcnt_q <= dcnt_q + DcntW'(1);
          end
        end
        StHeld: begin
          if (lc_high) begin
            dcnt_q  <= '0;
            state_q <= StRelease;
          end
        end
        StRelease: begin
          if (!lc_high) begin
            state_q <= StHeld;
          end else if (dcnt_q == DcntLast) begin
            key_held_q <= 1'b0;
            state_q    <= StScan;
            r_q        <= r_q + 2'd1;
            slot_q     <= '0;
          end else begin
            dcnt_q <= dcnt_q + DcntW'(1);
          end
        end
        default: state_q <= StScan;
      endcase
    end
  end

  assign row_o       = ~(4'b0001 << r_q);
  assign key_o       = key_q;
  assign key_valid_o = key_valid_q;
  assign key_held_o  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: emulates a physical 4x4 keypad against the row
// outputs and predicts scan position, accepted codes and latencies arithmetically.
module tb_keypad_scanner;

  localparam int SD = 4;
  localparam int DB = 8;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic [3:0]  col;
  logic [3:0]  row;
  logic [3:0]  key;
  logic        key_valid;
  logic        key_held;
  logic [15:0] pressed = '0;

  int tests = 0;
  int errors = 0;
  int cyc = 0;
  int base_row = 0;
  int base_t = 0;
  int pulses = 0;

  logic [3:0] code_tab [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                4'h4, 4'h5, 4'h6, 4'hB,
                                4'h7, 4'h8, 4'h9, 4'hC,
                                4'hE, 4'h0, 4'hF, 4'hD};

  keypad_scanner #(
    .SCAN_DIV       (SD),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk        (clk),
    .nreset     (nreset),
    .col_i      (col),
    .row_o      (row),
    .key_o      (key),
    .key_valid_o(key_valid),
    .key_held_o (key_held)
  );

  always #5 clk = ~clk;

  // Keypad emulation: a pressed key pulls its column low while its row is driven.
  always_comb begin
    col = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !row[r]) col[c] = 1'b0;
  end

  function automatic int mrow_idx();
    return (base_row + (cyc - base_t) / SD) % 4;
  endfunction

  function automatic logic [3:0] mrow();
    return ~(4'b0001 << mrow_idx());
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (key_valid) pulses++;
  endtask

  task automatic idle_steps(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      step();
      tests++;
      if (row !== mrow()) begin
        errors++;
        $display("FAIL %s row: got %b want %b at cyc %0d", name, row, mrow(), cyc);
      end
    end
  endtask

  // Advance to the start of a row slot (target < 0: any row).
  task automatic wait_slot(input int target);
    int n = 0;
    while (!(((cyc - base_t) % SD) == 0 && (target < 0 || mrow_idx() == target)) && n < 64) begin
      idle_steps(1, "wait_slot");
      n++;
    end
    tests++;
    if (n >= 64) begin
      errors++;
      $display("FAIL wait_slot timeout: target %0d", target);
    end
  endtask

  task automatic wait_valid(output int t);
    int n = 0;
    while (!key_valid && n < 200) begin
      step();
      n++;
    end
    t = cyc;
    tests++;
    if (!key_valid) begin
      errors++;
      $display("FAIL valid_timeout: got 0 want 1");
    end
  endtask

  task automatic wait_fall(output int t);
    int n = 0;
    while (key_held && n < 200) begin
      step();
      n++;
    end
    t = cyc;
    tests++;
    if (key_held) begin
      errors++;
      $display("FAIL held_fall_timeout: got 1 want 0");
    end
  endtask

  task automatic test_reset();
    nreset = 1'b0;
    pressed = '0;
    repeat (3) step();
    base_row = 0;
    base_t = cyc;
    tests++;
    if (row !== 4'b1110) begin errors++; $display("FAIL reset_row: got %b want 1110", row); end
    tests++;
    if (key !== 4'h0) begin errors++; $display("FAIL reset_key: got %h want 0", key); end
    tests++;
    if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", key_valid); end
    tests++;
    if (key_held !== 1'b0) begin errors++; $display("FAIL reset_held: got %b want 0", key_held); end
    nreset = 1'b1;
  endtask

  task automatic test_idle();
    idle_steps(20, "idle");
    tests++;
    if (pulses != 0) begin errors++; $display("FAIL idle_pulses: got %0d want 0", pulses); end
    tests++;
    if (key !== 4'h0) begin errors++; $display("FAIL idle_key: got %h want 0", key); end
  endtask

  task automatic test_clean_press();
    int t0, tv, tr, tf, p0;
    p0 = pulses;
    wait_slot(1);
    t0 = cyc;
    pressed[1*4+2] = 1'b1;
    wait_valid(tv);
    tests++;
    if (tv != t0 + SD + DB) begin errors++; $display("FAIL press6_latency: got %0d want %0d", tv - t0, SD + DB); end
    tests++;
    if (key !== 4'h6) begin errors++; $display("FAIL press6_key: got %h want 6", key); end
    tests++;
    if (key_held !== 1'b1) begin errors++; $display("FAIL press6_held: got %b want 1", key_held); end
    step();
    tests++;
    if (key_valid !== 1'b0) begin errors++; $display("FAIL press6_pulse_width: got %b want 0", key_valid); end
    for (int i = 0; i < 10; i++) begin
      step();
      tests++;
      if (row !== 4'b1101 || key_held !== 1'b1) begin
        errors++;
        $display("FAIL press6_hold: got row %b held %b want 1101 1", row, key_held);
      end
    end
    pressed = '0;
    tr = cyc;
    wait_fall(tf);
    tests++;
    if (tf != tr + 3 + DB) begin errors++; $display("FAIL press6_release_latency: got %0d want %0d", tf - tr, 3 + DB); end
    tests++;
    if (row !== 4'b1011) begin errors++; $display("FAIL press6_resume_row: got %b want 1011", row); end
    tests++;
    if (pulses != p0 + 1) begin errors++; $display("FAIL press6_pulses: got %0d want %0d", pulses - p0, 1); end
    base_row = 2;
    base_t = tf;
  endtask

  task automatic test_press_bounce();
    int p0;
    p0 = pulses;
    for (int k = 0; k < 2; k++) begin
      wait_slot(0);
      pressed[0] = 1'b1;
      repeat (5) step();
      pressed = '0;
      repeat (3) step();
      tests++;
      if (row !== 4'b1101) begin errors++; $display("FAIL bounce_abort_row: got %b want 1101", row); end
      tests++;
      if (key_held !== 1'b0) begin errors++; $display("FAIL bounce_held: got %b want 0", key_held); end
      base_row = 1;
      base_t = cyc;
      idle_steps(4, "bounce_scan");
    end
    tests++;
    if (pulses != p0) begin errors++; $display("FAIL bounce_pulses: got %0d want 0", pulses - p0); end
  endtask

  task automatic test_release_bounce();
    int t0, tv, tr, tf, p0;
    p0 = pulses;
    wait_slot(3);
    t0 = cyc;
    pressed[15] = 1'b1;
    wait_valid(tv);
    tests++;
    if (tv != t0 + SD + DB) begin errors++; $display("FAIL keyD_latency: got %0d want %0d", tv - t0, SD + DB); end
    tests++;
    if (key !== 4'hD) begin errors++; $display("FAIL keyD_key: got %h want d", key); end
    repeat (4) step();
    pressed[15] = 1'b0;
    for (int i = 0; i < 13; i++) begin
      if (i == 3) pressed[15] = 1'b1;
      step();
      tests++;
      if (key_held !== 1'b1) begin errors++; $display("FAIL keyD_bounce_held: got %b want 1", key_held); end
    end
    pressed = '0;
    tr = cyc;
    wait_fall(tf);
    tests++;
    if (tf != tr + 3 + DB) begin errors++; $display("FAIL keyD_release_latency: got %0d want %0d", tf - tr, 3 + DB); end
    tests++;
    if (pulses != p0 + 1) begin errors++; $display("FAIL keyD_pulses: got %0d want 1", pulses - p0); end
    base_row = 0;
    base_t = tf;
  endtask

  task automatic test_simultaneous();
    int t0, tv, tr, tf, p0;
    p0 = pulses;
    wait_slot(2);
    t0 = cyc;
    pressed[2*4+1] = 1'b1;
    pressed[2*4+3] = 1'b1;
    wait_valid(tv);
    tests++;
    if (tv != t0 + SD + DB) begin errors++; $display("FAIL simul_latency: got %0d want %0d", tv - t0, SD + DB); end
    tests++;
    if (key !== 4'h8) begin errors++; $display("FAIL simul_key: got %h want 8", key); end
    pressed[0] = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step();
      tests++;
      if (row !== 4'b1011 || key_held !== 1'b1 || key !== 4'h8) begin
        errors++;
        $display("FAIL simul_hold: got row %b held %b key %h want 1011 1 8", row, key_held, key);
      end
    end
    pressed = '0;
    tr = cyc;
    wait_fall(tf);
    tests++;
    if (tf != tr + 3 + DB) begin errors++; $display("FAIL simul_release_latency: got %0d want %0d", tf - tr, 3 + DB); end
    base_row = 3;
    base_t = tf;
    idle_steps(20, "simul_scan");
    tests++;
    if (pulses != p0 + 1) begin errors++; $display("FAIL simul_pulses: got %0d want 1", pulses - p0); end
  endtask

  task automatic test_reset_mid_debounce();
    int p0;
    p0 = pulses;
    wait_slot(1);
    pressed[1*4+0] = 1'b1;
    repeat (SD + 4) step();
    nreset = 1'b0;
    step();
    tests++;
    if (row !== 4'b1110) begin errors++; $display("FAIL rstmid_row: got %b want 1110", row); end
    tests++;
    if (key_held !== 1'b0) begin errors++; $display("FAIL rstmid_held: got %b want 0", key_held); end
    tests++;
    if (key !== 4'h0) begin errors++; $display("FAIL rstmid_key: got %h want 0", key); end
    tests++;
    if (key_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b want 0", key_valid); end
    pressed = '0;
    base_row = 0;
    base_t = cyc;
    nreset = 1'b1;
    idle_steps(30, "rstmid_scan");
    tests++;
    if (pulses != p0) begin errors++; $display("FAIL rstmid_pulses: got %0d want 0", pulses - p0); end
  endtask

  task automatic test_random();
    int t0, tv, tr, tf, p0, cur, nk, i1, i2, best, rank, wr, wc;
    for (int it = 0; it < 12; it++) begin
      p0 = pulses;
      idle_steps($urandom_range(0, 15), "rand_idle");
      wait_slot(-1);
      t0 = cyc;
      cur = mrow_idx();
      nk = $urandom_range(1, 2);
      i1 = $urandom_range(0, 15);
      i2 = i1;
      while (i2 == i1) i2 = $urandom_range(0, 15);
      pressed[i1] = 1'b1;
      if (nk == 2) pressed[i2] = 1'b1;
      // Rank by rows still to scan from the current one, then by column.
      best = 100;
      for (int k = 0; k < 16; k++) begin
        if (pressed[k]) begin
          rank = ((k / 4 - cur + 4) % 4) * 4 + (k % 4);
          if (rank < best) best = rank;
        end
      end
      wr = (cur + best / 4) % 4;
      wc = best % 4;
      wait_valid(tv);
      tests++;
      if (tv != t0 + (best / 4) * SD + SD + DB) begin
        errors++;
        $display("FAIL rand_latency it %0d: got %0d want %0d", it, tv - t0, (best / 4) * SD + SD + DB);
      end
      tests++;
      if (key !== code_tab[wr*4+wc]) begin
        errors++;
        $display("FAIL rand_key it %0d: got %h want %h", it, key, code_tab[wr*4+wc]);
      end
      tests++;
      if (row !== ~(4'b0001 << wr)) begin
        errors++;
        $display("FAIL rand_row it %0d: got %b want %b", it, row, ~(4'b0001 << wr));
      end
      repeat ($urandom_range(0, 10)) step();
      pressed = '0;
      tr = cyc;
      wait_fall(tf);
      tests++;
      if (tf != tr + 3 + DB) begin
        errors++;
        $display("FAIL rand_release_latency it %0d: got %0d want %0d", it, tf - tr, 3 + DB);
      end
      tests++;
      if (pulses != p0 + 1) begin errors++; $display("FAIL rand_pulses it %0d: got %0d want 1", it, pulses - p0); end
      base_row = (wr + 1) % 4;
      base_t = tf;
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_clean_press();
    test_press_bounce();
    test_release_bounce();
    test_simultaneous();
    test_reset_mid_debounce();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 matrix keypad and delivers one debounced key code per press. It is the input-side counterpart of the display time multiplexer: that block drives digits one at a time, and this block drives keypad rows one at a time and reads the columns back. It sits between the FPGA keypad pins and the digit-shift logic that feeds the display multiplexer.

## Interface
- SCAN_DIV, 12000: clk cycles per row slot (1 ms at 12 MHz); must be ≥ 4.
- DEBOUNCE_CYCLES, 240000: cycles a level must hold to count as a press or release (20 ms); must be ≥ 2.
- clk  in  1  system clock, 12 MHz.
- nreset  in  1  reset; synchronous, active-low.
- col  in  4  keypad columns, asynchronous, active-low (externally pulled up); bit i = column i.
- row  out  4  keypad rows, active-low, exactly one bit low at all times; bit i = row i.
- key  out  4  code of the last accepted key; holds until the next accepted press.
- key_valid  out  1  one-cycle pulse when a new key is accepted.
- key_held  out  1  high from acceptance until debounced release.

## Operation
- col passes through a 2-flop synchronizer (colsync). All decisions use colsync only.
- Row index r (2 bits) drives row = ~(1 << r). A slot counter counts 0..SCAN_DIV-1. tick = (slot counter == SCAN_DIV-1).
- Key map, row r / column c to code:
  - r0: 1, 2, 3, A
  - r1: 4, 5, 6, B
  - r2: 7, 8, 9, C
  - r3: E, 0, F, D
  - (E = '*', F = '#')
- FSM states: SCAN, DEBOUNCE, HELD, RELEASE. Latched column lc (2 bits). Debounce counter dcnt.
- SCAN:
  - The slot counter runs.
  - On tick with any colsync bit low: lc takes the lowest-index low column, r is frozen, dcnt is set to 0, and the FSM goes to DEBOUNCE.
  - On tick with no colsync bit low: r advances, wrapping 3 to 0.
- DEBOUNCE:
  - If colsync[lc] is high: go to SCAN, advance r, clear the slot counter.
  - Else if dcnt == DEBOUNCE_CYCLES-1: load key from map(r, lc), pulse key_valid, set key_held, go to HELD.
  - Else: dcnt increments.
- HELD:
  - r stays frozen. Other columns and rows are ignored; there is no rollover, and a second key pressed while holding produces nothing.
  - If colsync[lc] goes high: dcnt is set to 0 and the FSM goes to RELEASE.
- RELEASE:
  - If colsync[lc] is low: return to HELD with no new key_valid.
  - Else if dcnt == DEBOUNCE_CYCLES-1: clear key_held, go to SCAN, advance r, clear the slot counter.
  - Else: dcnt increments.
- Counter widths are $clog2 of the respective parameter. Counters never wrap outside the rules above.

## Timing
- Reset values (on the clk edge with nreset low):
  - state SCAN, r = 0, so row = 4'b1110
  - slot counter and dcnt = 0
  - key = 4'h0, key_valid = 0, key_held = 0
  - both synchronizer stages = 4'b1111
- Reset asserted mid-press (any state) gives exactly the values above on the next edge. No key_valid is emitted for a press interrupted by reset.
- All outputs are registered; there are no combinational paths from col.
- A pin change reaches colsync 2 cycles later.
- Idle scan: each row stays low for exactly SCAN_DIV cycles; the full cycle is 4*SCAN_DIV cycles.
- Press latency:
  - key_valid rises DEBOUNCE_CYCLES cycles after the first DEBOUNCE cycle.
  - key and key_held update on the same edge as key_valid rises.
  - key_valid is high for exactly 1 cycle.
- Release latency: key_held falls DEBOUNCE_CYCLES cycles after the first RELEASE cycle. row changes on that same edge.
- Simultaneous keys:
  - In SCAN, two low columns on the same row: the lowest column wins.
  - Keys on different rows: the first row scanned wins.
- A bounce shorter than DEBOUNCE_CYCLES in DEBOUNCE aborts the press.
- A bounce shorter than DEBOUNCE_CYCLES in RELEASE is absorbed with no repeat.

## Test plan
Use SCAN_DIV=4 and DEBOUNCE_CYCLES=8 unless noted.
- Reset and idle:
  - Stimulus: hold nreset low 3 cycles, then release with col=4'b1111.
  - Required: row = 1110 after reset; row sequence 1110, 1101, 1011, 0111, 1110, each for 4 cycles; key_valid never high; key=0.
- Clean press of '6' (r1, c2):
  - Stimulus: drive col[2] low only while row == 1101 and hold it.
  - Required: one key_valid pulse with key=4'h6 and key_held=1; row stays at 1101 while held; after col goes high, key_held falls 8 cycles after RELEASE entry and scanning resumes at row 1011.
- Press bounce:
  - Stimulus: on row 0 press col[0] for 5 cycles, release, then repeat the same 5-cycle press.
  - Required: no key_valid; FSM back in SCAN; r advances each time.
- Release bounce:
  - Stimulus: while 'D' (r3, c3) is held, raise col[3] for 3 cycles, lower it again for 10 cycles, then release.
  - Required: exactly one key_valid with key=4'hD; key_held stays 1 through the bounce.
- Simultaneous and ignored keys:
  - Stimulus: on row 2 drive columns 1 and 3 low, which is '8' and 'C'; while holding, also press '1' (r0, c0).
  - Required: key=4'h8 accepted once; the '1' press is ignored entirely.
- Reset mid-debounce:
  - Stimulus: assert nreset at dcnt=4 during a press.
  - Required: next-edge values are row=1110, key_held=0, key=0, key_valid=0, and no pulse follows.
